keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Matrix-keypad input block: drives the rows of a 4x4 active-low keypad one at a time and samples the columns. It decodes and debounces a single key press, then reports it as a 4-bit hex code with a one-cycle strobe. This block is the user-input counterpart to the multiplexed seven-segment display driver. Its key codes feed the same 5-bit-per-digit data bus that the display consumes.

## Interface
- `SCAN_PERIOD`, default 100000: clock cycles each row stays driven; must be ≥ 4.
- `DEBOUNCE_SCANS`, default 4: consecutive identical full-scan frames required to accept a press or a release; must be ≥ 2.
- `clk` input, 1 bit: system clock. All state is on its rising edge.
- `rst_n` input, 1 bit: reset. Asynchronous and active-low.
- `row` output, 4 bits: row drive, active-low, exactly one bit low at any time.
- `col` input, 4 bits: column sense, active-low (pulled up); asynchronous to `clk`.
- `key_code` output, 4 bits: code of the last accepted key, `{row_idx[1:0], col_idx[1:0]}`.
- `key_valid` output, 1 bit: one-cycle pulse when a press is accepted.
- `key_down` output, 1 bit: level, high while an accepted key is held.

## Operation
- `col` passes through a 2-flop synchronizer before any use.
- Tick counter:
  - counts 0..SCAN_PERIOD-1 and wraps;
  - `tick` is high in the cycle where the count equals SCAN_PERIOD-1.
- On `tick`:
  - sample the synchronized `col` for the current row;
  - then advance the row index 0→1→2→3→0;
  - `row` = ~(1 << row_idx).
- Frame: the 4 ticks covering rows 0..3. On the row-3 tick, the frame result is:
  - NONE: no column low in any row;
  - SINGLE(k): exactly one (row, col) low across the frame, with k = {row_idx, col_idx};
  - MULTI: more than one low. MULTI is treated as NONE for every state transition.
- A debounce counter (`cnt`) counts consecutive qualifying frames. FSM states and transitions, evaluated only at frame end:
  - IDLE: SINGLE(k) → cand=k, cnt=1, go to PRESS_DEB.
  - PRESS_DEB:
    - SINGLE(cand) → cnt+1; when cnt reaches DEBOUNCE_SCANS: key_code=cand, key_valid pulse, key_down=1, go to HELD.
    - SINGLE(other) → cand=other, cnt=1.
    - NONE → IDLE.
  - HELD:
    - NONE → cnt=1, go to RELEASE_DEB.
    - Any SINGLE → stay. No new press is reported until a release is accepted.
  - RELEASE_DEB:
    - NONE → cnt+1; when cnt reaches DEBOUNCE_SCANS: key_down=0, go to IDLE.
    - Any SINGLE → HELD.
- `key_code` holds its value after release until the next accepted press.
- Reset (async, any point mid-scan):
  - row_idx=0, `row`=4'b1110;
  - tick counter=0, state=IDLE, cnt=0, cand=0;
  - `key_code`=0, `key_valid`=0, `key_down`=0;
  - synchronizer flops=4'b1111.

## Timing
- Each row is driven for SCAN_PERIOD cycles before it is sampled. The synchronizer delay (2 cycles) is covered because SCAN_PERIOD ≥ 4.
- Frame length is 4·SCAN_PERIOD cycles.
- `key_valid` and `key_down` are registered. They change in the cycle after the frame-end tick.
- `key_valid` is high for exactly 1 cycle per accepted press.
- Press latency: from the first frame that fully sees the key, acceptance happens at the end of frame number DEBOUNCE_SCANS. Worst case from physical press to acceptance is (DEBOUNCE_SCANS+1)·4·SCAN_PERIOD + 3 cycles.
- Release latency: DEBOUNCE_SCANS NONE frames.
- `col` changes within a frame:
  - a key released mid-frame after its row was sampled still counts for that frame;
  - no sub-frame filtering beyond the synchronizer.
- Counter widths: tick counter is $clog2(SCAN_PERIOD) bits; cnt is $clog2(DEBOUNCE_SCANS+1) bits. No overflow, because cnt saturates at the threshold by the state change.

## Structure
- Shared package `keypad_pkg`:
  - FSM state enum (IDLE, PRESS_DEB, HELD, RELEASE_DEB);
  - frame-result encoding (NONE, SINGLE, MULTI);
  - row-count constant 4.
- One sub-module, `scan_tick_gen`: the parameterized SCAN_PERIOD divider producing `tick` and the 2-bit row index. It is reusable by the display driver's digit rotation.
- The top level holds the synchronizer, frame accumulator (first-hit code plus hit count, saturating at 2) and the FSM.

## Test plan
All scenarios use SCAN_PERIOD=4 and DEBOUNCE_SCANS=3 (frame = 16 cycles).
- **Async reset:** assert rst_n low mid-frame while row=4'b1011 → same instant: `row`=4'b1110, key_code=0, key_valid=0, key_down=0. After release, first row advance occurs 4 cycles later.
- **Clean press:** hold row2/col1 (col[1] low whenever row[2] low) for 6 frames → exactly one key_valid pulse with key_code=4'h9, at the end of the 3rd full frame. key_down=1 thereafter.
- **Press bounce:** key 4'h5 present for 2 frames, absent for 1, present for 3 → no pulse after the first 2 frames; one pulse with key_code=4'h5 after the later 3rd frame.
- **Release bounce:** after 4'h9 is accepted, absent for 2 frames then present again → key_down stays 1 and no new pulse. Then absent for 3 frames → key_down=0 at the end of the 3rd frame, key_code stays 4'h9.
- **Multi-key:** row0/col0 and row0/col3 held together for 5 frames → no pulse, key_down=0, state remains IDLE.
- **Key switch while held:** 4'h9 accepted, then switched directly to 4'hF with no NONE frame → no pulse, key_code stays 4'h9. Then release for 3 frames and press 4'hF for 3 frames → one pulse with key_code=4'hF.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
// Also provides the row-drive helper used wherever a row index becomes an active-low select.
package keypad_pkg;

    localparam int ROWS = 4;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_DEB,
        HELD,
        RELEASE_DEB
    } state_t;

    typedef enum logic [1:0] {
        FRAME_NONE,
        FRAME_SINGLE,
        FRAME_MULTI
    } frame_t;

    function automatic logic [3:0] row_drive(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Divides the clock by PERIOD to produce a one-cycle tick and a rotating 2-bit index.
// The same divider can drive the digit rotation of the seven-segment display.
module scan_tick_gen #(
    parameter int PERIOD = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       tick,
    output logic [1:0] row_idx
);

    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0] count;

    assign tick = (count == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            row_idx <= 2'd0;
        end else if (tick) begin
            count   <= '0;
            row_idx <= row_idx + 2'd1;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner: row rotation, per-frame hit accumulation,
// and a press/release debounce FSM reporting one key as a hex code plus strobe.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_PERIOD    = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [3:0] row,
    input  logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);

    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS - 1);

    logic       tick;
    logic [1:0] row_idx;
    logic [3:0] col_meta;
    logic [3:0] col_sync;

    logic [3:0] hit_code;
    logic [1:0] hit_cnt;

    logic [3:0] col_hits;
    logic [2:0] hit_total;
    logic [1:0] first_col;
    logic [3:0] hit_sum;
    logic [1:0] acc_cnt;
    logic [3:0] acc_code;
    logic       frame_end;
    frame_t     frame_res;
    logic       single;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       cand;

    scan_tick_gen #(
        .PERIOD(SCAN_PERIOD)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick   (tick),
        .row_idx(row_idx)
    );

    assign row = row_drive(row_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_meta <= 4'b1111;
            col_sync <= 4'b1111;
        end else begin
            col_meta <= col;
            col_sync <= col_meta;
        end
    end

    // Merge this row's sample into the frame so far; the lowest low column gives the code.
    always_comb begin
        col_hits  = ~col_sync;
        hit_total = 3'd0;
        first_col = 2'd0;
        for (int c = ROWS - 1; c >= 0; c--) begin
            if (col_hits[c]) begin
                hit_total = hit_total + 3'd1;
                first_col = 2'(c);
            end
        end
        hit_sum   = {1'b0, hit_total} + {2'b00, hit_cnt};
        acc_cnt   = (hit_sum >= 4'd2) ? 2'd2 : hit_sum[1:0];
        acc_code  = (hit_cnt == 2'd0) ? {row_idx, first_col} : hit_code;
        frame_end = tick && (row_idx == 2'(ROWS - 1));
        case (acc_cnt)
            2'd0:    frame_res = FRAME_NONE;
            2'd1:    frame_res = FRAME_SINGLE;
            default: frame_res = FRAME_MULTI;
        endcase
        single = (frame_res == FRAME_SINGLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt  <= 2'd0;
            hit_code <= 4'd0;
        end else if (frame_end) begin
            hit_cnt  <= 2'd0;
            hit_code <= 4'd0;
        end else if (tick) begin
            hit_cnt  <= acc_cnt;
            hit_code <= acc_code;
        end
    end

    // MULTI frames fall through the !single paths, so they behave exactly like NONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            cand      <= 4'd0;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (frame_end) begin
                case (state)
                    IDLE: begin
                        if (single) begin
                            cand  <= acc_code;
                            cnt   <= CNT_W'(1);
                            state <= PRESS_DEB;
                        end
                    end
                    PRESS_DEB: begin
                        if (single && acc_code == cand) begin
                            cnt <= cnt + 1'b1;
                            if (cnt == CNT_LAST) begin
                                key_code  <= cand;
                                key_valid <= 1'b1;
                                key_down  <= 1'b1;
                                state     <= HELD;
                            end
                        end else if (single) begin
                            cand <= acc_code;
                            cnt  <= CNT_W'(1);
                        end else begin
                            state <= IDLE;
                        end
                    end
                    HELD: begin
                        if (!single) begin
                            cnt   <= CNT_W'(1);
                            state <= RELEASE_DEB;
                        end
                    end
                    RELEASE_DEB: begin
                        if (!single) begin
                            cnt <= cnt + 1'b1;
                            if (cnt == CNT_LAST) begin
                                key_down <= 1'b0;
                                state    <= IDLE;
                            end
                        end else begin
                            state <= HELD;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad model drives col from row, and expected
// press strobes (code and arrival cycle) are queued and matched by a monitor.
module tb_keypad_scanner;

    localparam int SCAN_PERIOD    = 4;
    localparam int DEBOUNCE_SCANS = 3;
    localparam int FRAME          = 4 * SCAN_PERIOD;

    typedef struct {
        logic [3:0] code;
        int         cycle;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_down;
    logic [15:0] pressed = 16'h0000;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   push_count = 0;
    int   pulse_count = 0;
    exp_t sb[$];

    keypad_scanner #(
        .SCAN_PERIOD   (SCAN_PERIOD),
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .row      (row),
        .col      (col),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_down (key_down)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // A pressed key at (r, c) pulls column c low while row r is driven low.
    always_comb begin
        col = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!row[r] && pressed[r*4+c]) col[c] = 1'b0;
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] mask, input int frames);
        pressed = mask;
        repeat (frames * FRAME) @(negedge clk);
    endtask

    task automatic expectPress(input logic [3:0] code, input int frames_ahead);
        exp_t e;
        e.code  = code;
        e.cycle = cyc + frames_ahead * FRAME;
        sb.push_back(e);
        push_count++;
    endtask

    always @(negedge clk) begin
        if (rst_n && key_valid) begin
            exp_t e;
            pulse_count++;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput("pulse_code", int'(key_code), int'(e.code));
                checkOutput("pulse_cycle", cyc, e.cycle);
            end
        end
    end

    initial begin
        int guard;

        repeat (3) @(negedge clk);
        checkOutput("rst_row", int'(row), 4'b1110);
        checkOutput("rst_code", int'(key_code), 0);
        checkOutput("rst_valid", int'(key_valid), 0);
        checkOutput("rst_down", int'(key_down), 0);
        rst_n = 1'b1;

        guard = 0;
        while (row != 4'b0111 && guard < 100) begin @(negedge clk); guard++; end
        while (row != 4'b1110 && guard < 100) begin @(negedge clk); guard++; end
        checkOutput("align_row", int'(row), 4'b1110);

        // Clean press of 9 held six frames: accepted at the end of frame 3.
        expectPress(4'h9, 3);
        applyStimulus(16'h0200, 6);
        checkOutput("clean_down", int'(key_down), 1);
        checkOutput("clean_code", int'(key_code), 4'h9);

        // Release bounce, then a real release.
        applyStimulus(16'h0000, 2);
        checkOutput("relb_down_a", int'(key_down), 1);
        applyStimulus(16'h0200, 1);
        checkOutput("relb_down_b", int'(key_down), 1);
        applyStimulus(16'h0000, 2);
        checkOutput("rel_down_2", int'(key_down), 1);
        applyStimulus(16'h0000, 1);
        checkOutput("rel_down_3", int'(key_down), 0);
        checkOutput("rel_code", int'(key_code), 4'h9);

        // Press bounce on key 5.
        expectPress(4'h5, 6);
        applyStimulus(16'h0020, 2);
        applyStimulus(16'h0000, 1);
        checkOutput("pb_down_gap", int'(key_down), 0);
        applyStimulus(16'h0020, 2);
        checkOutput("pb_down_early", int'(key_down), 0);
        applyStimulus(16'h0020, 1);
        checkOutput("pb_down", int'(key_down), 1);
        checkOutput("pb_code", int'(key_code), 4'h5);
        applyStimulus(16'h0000, 3);
        checkOutput("pb_release", int'(key_down), 0);

        // Two keys in row 0 at once: never accepted.
        applyStimulus(16'h0009, 5);
        checkOutput("multi_down", int'(key_down), 0);
        checkOutput("multi_code", int'(key_code), 4'h5);

        // Switch from 9 to F while held, then release and press F.
        expectPress(4'h9, 3);
        applyStimulus(16'h0200, 3);
        applyStimulus(16'h8000, 3);
        checkOutput("sw_code", int'(key_code), 4'h9);
        checkOutput("sw_down", int'(key_down), 1);
        applyStimulus(16'h0000, 3);
        checkOutput("sw_release", int'(key_down), 0);
        expectPress(4'hF, 3);
        applyStimulus(16'h8000, 3);
        checkOutput("sw_new_code", int'(key_code), 4'hF);
        checkOutput("sw_new_down", int'(key_down), 1);

        // Asynchronous reset mid-frame while row 2 is driven.
        guard = 0;
        while (row != 4'b1011 && guard < 100) begin @(negedge clk); guard++; end
        checkOutput("wait_row2", int'(row), 4'b1011);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_row", int'(row), 4'b1110);
        checkOutput("async_code", int'(key_code), 0);
        checkOutput("async_valid", int'(key_valid), 0);
        checkOutput("async_down", int'(key_down), 0);
        pressed = 16'h0000;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("post_rst_hold", int'(row), 4'b1110);
        @(posedge clk);
        #1;
        checkOutput("post_rst_adv", int'(row), 4'b1101);

        repeat (2 * FRAME) @(negedge clk);
        checkOutput("pulse_count", pulse_count, push_count);
        checkOutput("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
